key_digit_buffer: RTL and testbench
===================================

// Module: key_digit_buffer
// PURPOSE
//   Downstream consumer of the matrix-keyboard scanner. Takes the scanner's decoded
//   key code plus a key-held level, debounces press and release, and edits a
//   NUM_DIGITS-digit BCD entry buffer (digit shift-in, backspace, clear).
//   Drives a time-multiplexed common-anode 7-segment display of that buffer.
// PARAMETERS
//   NUM_DIGITS       4     digits held and displayed (2..8)
//   DEBOUNCE_CYCLES  4     consecutive stable samples required for press and for release (>=1)
//   SCAN_DIV         1000  clk cycles per displayed digit before advancing the scan
// PORTS
//   clk          in   1               system clock, all state on rising edge
//   rst_n        in   1               asynchronous active-low reset
//   key_valid    in   1               high while scanner reports a key held
//   key_code     in   4               scanner key code, meaningful when key_valid=1
//   key_event    out  1               1-cycle pulse when an accepted press is applied
//   digits       out  4*NUM_DIGITS    packed BCD buffer, digit 0 (newest) in [3:0]
//   digit_count  out  $clog2(NUM_DIGITS+1)   number of valid digits, 0..NUM_DIGITS
//   seg_sel      out  NUM_DIGITS      active-low digit enable, exactly one bit low
//   codeout      out  8               segment pattern {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, digits=0, digit_count=0, key_event=0,
//     scan index=0, seg_sel=~1 (digit 0 enabled), codeout=8'hFF (blank).
//   Key codes: 0x0-0x9 digit; 0xE backspace; 0xF clear; 0xA-0xD ignored
//     (debounced and consumed, no buffer change, no key_event).
//   FSM (registered):
//     IDLE:     key_valid=1 -> DEBOUNCE, latch key_code, cnt=1.
//     DEBOUNCE: key_valid=0 -> IDLE; key_code != latched -> relatch, cnt=1;
//               else cnt++; when cnt reaches DEBOUNCE_CYCLES -> APPLY.
//     APPLY:    one cycle; performs edit, pulses key_event (if not ignored) -> HELD.
//     HELD:     key_valid=1 (any code) resets release cnt; key_valid=0 counts;
//               DEBOUNCE_CYCLES consecutive lows -> IDLE. No autorepeat.
//   Latency: key_event high exactly DEBOUNCE_CYCLES+1 cycles after the first
//     sampled key_valid=1 of an uninterrupted stable press.
//   Edits (effective on clock edge ending APPLY):
//     digit d: digits <= {digits[4*(N-1)-1:0], d}; digit_count saturates at N
//       (full buffer: oldest digit discarded, count stays N).
//     backspace: digits <= digits >> 4; digit_count-- (no-op at 0, key_event
//       still pulses).
//     clear: digits <= 0, digit_count <= 0.
//   Display: free-running divider 0..SCAN_DIV-1; on wrap, scan index advances
//     0..N-1 and wraps to 0. seg_sel and codeout registered, updated together.
//     Position i >= digit_count shows blank 8'hFF, except position 0 shows "0"
//     when digit_count=0. dp always off (bit7=1).
//   Segment table: 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90, blank FF.
//   Reset mid-press: FSM to IDLE, buffer cleared; a still-held key must be fully
//     re-debounced before it is accepted.
// STRUCTURE
//   Shared package keypad_pkg: key code constants (KEY_BKSP=4'hE, KEY_CLR=4'hF),
//     FSM state encoding (IDLE, DEBOUNCE, APPLY, HELD), SEG_BLANK=8'hFF.
//   One sub-module seg7_decode: 4-bit BCD + blank flag -> 8-bit active-low pattern,
//     purely combinational, reused by other display blocks.
//   Debounce FSM, buffer and scan divider remain in this module.
// TESTING
//   Press 4'h5 for 6 cycles (DEBOUNCE_CYCLES=4) -> key_event at cycle 5, digits[3:0]=5,
//     digit_count=1; hold 20 more cycles -> no further key_event.
//   Glitch: key_valid high 2 cycles then low -> no key_event, state back to IDLE.
//   Enter 1,2,3,4,5 (N=4) -> digits=16'h2345, digit_count=4.
//   Code change 3->7 mid-debounce, then stable 4 -> single key_event, digit 7 stored.
//   From 16'h0123/count 3: 0xE -> 16'h0012/count 2; 0xF -> 0/count 0; 0xE at 0 -> no
//     change, key_event pulses; 0xB -> no change, no key_event.
//   Display with SCAN_DIV=4, digits=16'h0089, count 2 -> seg_sel cycles E,D,B,7 every 4 clks,
//     codeout 90,80,FF,FF; rst_n low mid-press -> all outputs at reset values immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared keypad constants, debounce FSM encoding, segment blank.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_CLR   = 4'hF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        APPLY    = 2'd2,
        HELD     = 2'd3
    } kb_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : BCD + blank flag to active-low {dp,g,f,e,d,c,b,a} pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import keypad_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = 8'hC0;
                4'd1:    seg = 8'hF9;
                4'd2:    seg = 8'hA4;
                4'd3:    seg = 8'hB0;
                4'd4:    seg = 8'h99;
                4'd5:    seg = 8'h92;
                4'd6:    seg = 8'h82;
                4'd7:    seg = 8'hF8;
                4'd8:    seg = 8'h80;
                4'd9:    seg = 8'h90;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : key_digit_buffer
// Description : Debounced keypad entry into a BCD buffer with muxed 7-seg drive.
// Revision    : 1.0 - initial release
// ============================================================================
module key_digit_buffer
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    output logic                              key_event,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic [NUM_DIGITS-1:0]             seg_sel,
    output logic [7:0]                        codeout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW    = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    C_FULL     = CW'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);

    kb_state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [3:0]               r_code, w_code_nxt;
    logic                     r_key_event;
    logic [4*NUM_DIGITS-1:0]  r_digits;
    logic [CW-1:0]            r_count;
    logic [DIV_W-1:0]         r_div;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_DIGITS-1:0]    r_seg_sel;
    logic [7:0]               r_codeout;
    logic [3:0]               w_cur_digit;
    logic                     w_blank;
    logic [7:0]               w_seg;

    // ---------------- debounce FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // r_cnt counts stable press samples in DEBOUNCE and low samples in HELD
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        case (r_state)
            IDLE: begin
                if (key_valid) begin
                    w_code_nxt  = key_code;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (DEBOUNCE_CYCLES <= 1) ? APPLY : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_valid) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (key_code != r_code) begin
                    w_code_nxt = key_code;
                    w_cnt_nxt  = CNT_W'(1);
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = APPLY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            APPLY: begin
                w_state_nxt = HELD;
                w_cnt_nxt   = '0;
            end
            HELD: begin
                if (key_valid) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- entry buffer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_event <= 1'b0;
            r_digits    <= '0;
            r_count     <= '0;
        end else begin
            r_key_event <= 1'b0;
            if (r_state == APPLY) begin
                if (is_digit(r_code)) begin
                    r_digits    <= {r_digits[4*NUM_DIGITS-5:0], r_code};
                    r_key_event <= 1'b1;
                    if (r_count != C_FULL)
                        r_count <= r_count + CW'(1);
                end else if (r_code == KEY_BKSP) begin
                    r_digits    <= r_digits >> 4;
                    r_key_event <= 1'b1;
                    if (r_count != '0)
                        r_count <= r_count - CW'(1);
                end else if (r_code == KEY_CLR) begin
                    r_digits    <= '0;
                    r_count     <= '0;
                    r_key_event <= 1'b1;
                end
            end
        end
    end

    // ---------------- display scan ----------------
    assign w_cur_digit = r_digits[4*r_idx +: 4];
    // An empty buffer still shows a single "0" at position 0
    assign w_blank = (int'(r_idx) >= int'(r_count)) && !((r_idx == '0) && (r_count == '0));

    seg7_decode u_seg7_decode (
        .bcd   (w_cur_digit),
        .blank (w_blank),
        .seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_idx     <= '0;
            r_seg_sel <= ~NUM_DIGITS'(1);
            r_codeout <= SEG_BLANK;
        end else begin
            if (r_div == C_DIV_LAST) begin
                r_div <= '0;
                r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            r_seg_sel <= ~(NUM_DIGITS'(1) << r_idx);
            r_codeout <= w_seg;
        end
    end

    assign key_event   = r_key_event;
    assign digits      = r_digits;
    assign digit_count = r_count;
    assign seg_sel     = r_seg_sel;
    assign codeout     = r_codeout;

endmodule
`default_nettype wire

// File: tb/tb_key_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_digit_buffer
// Description : Directed, table-driven self-checking bench for key_digit_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_digit_buffer;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int DIV = 4;

    logic          clk;
    logic          rst_n;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_event;
    logic [15:0]   digits;
    logic [2:0]    digit_count;
    logic [3:0]    seg_sel;
    logic [7:0]    codeout;

    int checks = 0;
    int errors = 0;

    key_digit_buffer #(
        .NUM_DIGITS      (N),
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_DIV        (DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_event   (key_event),
        .digits      (digits),
        .digit_count (digit_count),
        .seg_sel     (seg_sel),
        .codeout     (codeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (actual timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Hold a key for 'hold' cycles, release long enough to return to IDLE
    task automatic press(input logic [3:0] code, input int hold, output int events);
        events = 0;
        for (int i = 0; i < hold; i++) begin
            key_valid = 1'b1;
            key_code  = code;
            @(negedge clk);
            events += int'(key_event);
        end
        key_valid = 1'b0;
        for (int i = 0; i < DEB + 3; i++) begin
            @(negedge clk);
            events += int'(key_event);
        end
    endtask

    // Key held from now: key_event must appear on exactly the 5th sample
    task automatic latency(input logic [3:0] code, input string name);
        key_valid = 1'b1;
        key_code  = code;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk(name, {31'd0, key_event}, {31'd0, (j == DEB + 1)});
        end
        key_valid = 1'b0;
        repeat (DEB + 3) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  code;
        int          hold;
        int          exp_events;
        logic [15:0] exp_digits;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          ev;
        int          k;
        int          n;
        logic        found;
        logic [3:0]  s0;
        logic [3:0]  seq_sel[4];
        logic [7:0]  seq_code[4];

        vecs[0]  = '{4'h5, 26, 1, 16'h0005, 3'd1};
        vecs[1]  = '{4'hF,  6, 1, 16'h0000, 3'd0};
        vecs[2]  = '{4'h1,  6, 1, 16'h0001, 3'd1};
        vecs[3]  = '{4'h2,  6, 1, 16'h0012, 3'd2};
        vecs[4]  = '{4'h3,  6, 1, 16'h0123, 3'd3};
        vecs[5]  = '{4'hE,  6, 1, 16'h0012, 3'd2};
        vecs[6]  = '{4'hF,  6, 1, 16'h0000, 3'd0};
        vecs[7]  = '{4'hE,  6, 1, 16'h0000, 3'd0};
        vecs[8]  = '{4'hB,  6, 0, 16'h0000, 3'd0};
        vecs[9]  = '{4'h1,  6, 1, 16'h0001, 3'd1};
        vecs[10] = '{4'h2,  6, 1, 16'h0012, 3'd2};
        vecs[11] = '{4'h3,  6, 1, 16'h0123, 3'd3};
        vecs[12] = '{4'h4,  6, 1, 16'h1234, 3'd4};
        vecs[13] = '{4'h5,  6, 1, 16'h2345, 3'd4};
        vecs[14] = '{4'hF,  6, 1, 16'h0000, 3'd0};

        seq_sel[0] = 4'hE; seq_sel[1] = 4'hD; seq_sel[2] = 4'hB; seq_sel[3] = 4'h7;
        seq_code[0] = 8'h90; seq_code[1] = 8'h80; seq_code[2] = 8'hFF; seq_code[3] = 8'hFF;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_key_event",   {31'd0, key_event}, 32'd0);
        chk("rst_digits",      {16'd0, digits}, 32'd0);
        chk("rst_digit_count", {29'd0, digit_count}, 32'd0);
        chk("rst_seg_sel",     {28'd0, seg_sel}, 32'hE);
        chk("rst_codeout",     {24'd0, codeout}, 32'hFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        latency(4'h6, "first_press_latency");
        press(4'hF, 6, ev);

        for (int i = 0; i < 15; i++) begin
            press(vecs[i].code, vecs[i].hold, ev);
            chk($sformatf("vec%0d_events", i), ev, vecs[i].exp_events);
            chk($sformatf("vec%0d_digits", i), {16'd0, digits}, {16'd0, vecs[i].exp_digits});
            chk($sformatf("vec%0d_count", i), {29'd0, digit_count}, {29'd0, vecs[i].exp_count});
        end

        // Glitch: two high samples must not be accepted
        press(4'h5, 2, ev);
        chk("glitch_events", ev, 0);
        chk("glitch_digits", {16'd0, digits}, 32'd0);
        latency(4'h4, "post_glitch_latency");
        chk("post_glitch_digits", {16'd0, digits}, 32'h0004);

        // Code change 3 -> 7 during debounce
        ev = 0;
        key_valid = 1'b1;
        key_code  = 4'h3;
        repeat (2) begin
            @(negedge clk);
            ev += int'(key_event);
        end
        press(4'h7, 6, k);
        chk("code_change_events", ev + k, 1);
        chk("code_change_digits", {16'd0, digits}, 32'h0047);
        chk("code_change_count",  {29'd0, digit_count}, 32'd2);

        // Display scan of 0x0089
        press(4'hF, 6, ev);
        press(4'h8, 6, ev);
        press(4'h9, 6, ev);
        chk("disp_digits", {16'd0, digits}, 32'h0089);
        s0 = seg_sel;
        n  = 0;
        while (seg_sel == s0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("disp_advance_timeout", {31'd0, (n >= 10)}, 32'd0);
        found = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (seg_sel == seq_sel[i] && !found) begin
                k = i;
                found = 1'b1;
            end
        end
        chk("disp_seg_sel_valid", {31'd0, found}, 32'd1);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("disp_seg_sel_%0d", j), {28'd0, seg_sel}, {28'd0, seq_sel[(k + j / 4) % 4]});
            chk($sformatf("disp_codeout_%0d", j), {24'd0, codeout}, {24'd0, seq_code[(k + j / 4) % 4]});
            @(negedge clk);
        end

        // Reset mid-press, key still held afterwards
        key_valid = 1'b1;
        key_code  = 4'h9;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_key_event",   {31'd0, key_event}, 32'd0);
        chk("midrst_digits",      {16'd0, digits}, 32'd0);
        chk("midrst_digit_count", {29'd0, digit_count}, 32'd0);
        chk("midrst_seg_sel",     {28'd0, seg_sel}, 32'hE);
        chk("midrst_codeout",     {24'd0, codeout}, 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        latency(4'h9, "post_reset_latency");
        chk("post_reset_digits", {16'd0, digits}, 32'h0009);
        chk("post_reset_count",  {29'd0, digit_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
